// File: rtl/lsu_pkg.sv
// Load/store unit shared types: size encodings, FSM states
// and byte-lane helper functions.
package lsu_pkg;

   localparam logic [1:0] LSU_BYTE    = 2'd0;
   localparam logic [1:0] LSU_HALF    = 2'd1;
   localparam logic [1:0] LSU_WORD    = 2'd2;
   localparam logic [1:0] LSU_ILLEGAL = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } lsu_state_t;

   // Lane offset actually used; misaligned low bits are dropped.
   function automatic logic [1:0] lsu_offset(
      input logic [1:0] size,
      input logic [1:0] addr
   );
      case (size)
         LSU_HALF: return {addr[1], 1'b0};
         LSU_WORD: return 2'b00;
         default:  return addr;
      endcase
   endfunction

   function automatic logic [3:0] lsu_mask(
      input logic [1:0] size,
      input logic [1:0] off
   );
      case (size)
         LSU_BYTE: return 4'b0001 << off;
         LSU_HALF: return 4'b0011 << off;
         LSU_WORD: return 4'b1111;
         default:  return 4'b0000;
      endcase
   endfunction

   function automatic logic [4:0] lsu_shift(input logic [1:0] off);
      return {off, 3'b000};
   endfunction

   function automatic logic lsu_misaligned(
      input logic [1:0] size,
      input logic [1:0] addr
   );
      case (size)
         LSU_HALF: return addr[0];
         LSU_WORD: return |addr;
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake and RAM port bundle of the
// load/store unit.
interface load_store_unit_if;

   logic        req_valid_in;
   logic        req_ready_out;
   logic        req_write_in;
   logic [1:0]  req_size_in;
   logic        req_unsigned_in;
   logic [31:0] req_address_in;
   logic [31:0] req_value_in;

   logic        rsp_valid_out;
   logic        rsp_ready_in;
   logic [31:0] rsp_value_out;
   logic        rsp_fault_out;

   logic [31:0] ram_address_out;
   logic [3:0]  ram_write_mask_out;
   logic [31:0] ram_write_value_out;
   logic [31:0] ram_read_value_in;

   modport master (
      output req_valid_in, req_write_in, req_size_in,
      output req_unsigned_in, req_address_in, req_value_in,
      output rsp_ready_in, ram_read_value_in,
      input  req_ready_out, rsp_valid_out, rsp_value_out,
      input  rsp_fault_out, ram_address_out,
      input  ram_write_mask_out, ram_write_value_out
   );

   modport slave (
      input  req_valid_in, req_write_in, req_size_in,
      input  req_unsigned_in, req_address_in, req_value_in,
      input  rsp_ready_in, ram_read_value_in,
      output req_ready_out, rsp_valid_out, rsp_value_out,
      output rsp_fault_out, ram_address_out,
      output ram_write_mask_out, ram_write_value_out
   );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment: store mask and lane replication,
// load extraction with sign/zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size_in,
   input  logic        unsigned_in,
   input  logic        write_in,
   input  logic [1:0]  offset_in,
   input  logic [31:0] store_value_in,
   input  logic [31:0] read_value_in,
   output logic [3:0]  write_mask_out,
   output logic [31:0] write_value_out,
   output logic [31:0] load_value_out
);

   logic [31:0] shifted;

   always_comb begin
      write_mask_out  = 4'b0000;
      write_value_out = store_value_in;
      load_value_out  = 32'd0;
      shifted         = read_value_in >> lsu_shift(offset_in);
      if (write_in) begin
         write_mask_out = lsu_mask(size_in, offset_in);
      end
      case (size_in)
         LSU_BYTE: begin
            write_value_out = {4{store_value_in[7:0]}};
            load_value_out  = unsigned_in
               ? {24'd0, shifted[7:0]}
               : {{24{shifted[7]}}, shifted[7:0]};
         end
         LSU_HALF: begin
            write_value_out = {2{store_value_in[15:0]}};
            load_value_out  = unsigned_in
               ? {16'd0, shifted[15:0]}
               : {{16{shifted[15]}}, shifted[15:0]};
         end
         default: begin
            load_value_out = shifted;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> ACCESS -> RESPOND.
// LSU_MISALIGN_TRAP_EN makes misaligned half/word accesses fault.
module load_store_unit
   import lsu_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   load_store_unit_if.slave bus
);

   lsu_state_t  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        unsigned_q, unsigned_d;
   logic        write_q, write_d;
   logic [31:0] store_q, store_d;
   logic [31:0] rsp_value_q, rsp_value_d;
   logic        rsp_fault_q, rsp_fault_d;

   logic        req_illegal;
   logic        in_access;
   logic        in_respond;
   logic [3:0]  align_mask;
   logic [31:0] align_wdata;
   logic [31:0] align_load;

   lsu_align u_align (
      .size_in        (size_q),
      .unsigned_in    (unsigned_q),
      .write_in       (write_q),
      .offset_in      (lsu_offset(size_q, addr_q[1:0])),
      .store_value_in (store_q),
      .read_value_in  (bus.ram_read_value_in),
      .write_mask_out (align_mask),
      .write_value_out(align_wdata),
      .load_value_out (align_load)
   );

   always_comb begin
      req_illegal = (bus.req_size_in == LSU_ILLEGAL);
`ifdef LSU_MISALIGN_TRAP_EN
      req_illegal = req_illegal |
         lsu_misaligned(bus.req_size_in, bus.req_address_in[1:0]);
`else
      req_illegal = req_illegal | 1'b0;
`endif
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      size_d      = size_q;
      unsigned_d  = unsigned_q;
      write_d     = write_q;
      store_d     = store_q;
      rsp_value_d = rsp_value_q;
      rsp_fault_d = rsp_fault_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid_in) begin
               addr_d      = bus.req_address_in;
               size_d      = bus.req_size_in;
               unsigned_d  = bus.req_unsigned_in;
               write_d     = bus.req_write_in;
               store_d     = bus.req_value_in;
               rsp_value_d = 32'd0;
               rsp_fault_d = req_illegal;
               state_d     = req_illegal ? RESPOND : ACCESS;
            end
         end
         ACCESS: begin
            rsp_value_d = write_q ? 32'd0 : align_load;
            rsp_fault_d = 1'b0;
            state_d     = RESPOND;
         end
         RESPOND: begin
            if (bus.rsp_ready_in) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= 32'd0;
         size_q      <= LSU_BYTE;
         unsigned_q  <= 1'b0;
         write_q     <= 1'b0;
         store_q     <= 32'd0;
         rsp_value_q <= 32'd0;
         rsp_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         unsigned_q  <= unsigned_d;
         write_q     <= write_d;
         store_q     <= store_d;
         rsp_value_q <= rsp_value_d;
         rsp_fault_q <= rsp_fault_d;
      end
   end

   // RAM port is live only in ACCESS, so each store writes once.
   assign in_access  = (state_q == ACCESS);
   assign in_respond = (state_q == RESPOND);

   assign bus.req_ready_out       = (state_q == IDLE);
   assign bus.rsp_valid_out       = in_respond;
   assign bus.rsp_value_out       = in_respond ? rsp_value_q : 32'd0;
   assign bus.rsp_fault_out       = in_respond & rsp_fault_q;
   assign bus.ram_address_out     =
      in_access ? {addr_q[31:2], 2'b00} : 32'd0;
   assign bus.ram_write_mask_out  = in_access ? align_mask : 4'b0000;
   assign bus.ram_write_value_out = in_access ? align_wdata : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-memory model
// and a per-cycle compare process.
module tb_load_store_unit;

   logic clk = 1'b0;
   logic reset = 1'b1;

   load_store_unit_if bus();

   load_store_unit dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   int total = 0;
   int bad = 0;

   logic [7:0]  ram [256];
   logic [7:0]  ref_mem [256];
   logic [31:0] exp_value = 32'd0;
   logic [31:0] exp_addr = 32'd0;
   logic [31:0] exp_wdata = 32'd0;
   logic [3:0]  exp_mask = 4'd0;
   logic        exp_fault = 1'b0;
   logic [3:0]  last_mask = 4'd0;
   int          access_seen = 0;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // RAM: samples address at negedge, read-before-write.
   always @(negedge clk) begin
      logic [7:0] a;
      a = bus.ram_address_out[7:0];
      bus.ram_read_value_in = {ram[a + 8'd3], ram[a + 8'd2],
                               ram[a + 8'd1], ram[a]};
      for (int i = 0; i < 4; i++) begin
         if (bus.ram_write_mask_out[i]) begin
            ram[a + 8'(i)] = bus.ram_write_value_out[8*i +: 8];
         end
      end
   end

   // Compare process: checks outputs on every negedge out of reset.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.rsp_valid_out) begin
            chk("rsp_value", bus.rsp_value_out, exp_value);
            chk("rsp_fault", {31'd0, bus.rsp_fault_out},
                {31'd0, exp_fault});
            chk("ready_in_respond", {31'd0, bus.req_ready_out}, 32'd0);
         end else if (!bus.req_ready_out) begin
            access_seen++;
            last_mask = bus.ram_write_mask_out;
            chk("ram_mask", {28'd0, bus.ram_write_mask_out},
                {28'd0, exp_mask});
            chk("ram_addr", bus.ram_address_out, exp_addr);
            if (exp_mask != 4'd0) begin
               chk("ram_wdata", bus.ram_write_value_out, exp_wdata);
            end
         end else begin
            chk("idle_mask", {28'd0, bus.ram_write_mask_out}, 32'd0);
         end
      end
   end

   // One transaction; called #1 after a posedge while IDLE.
   task automatic do_req(input bit w, input logic [1:0] sz,
                         input bit u, input logic [31:0] a,
                         input logic [31:0] v, input int hold,
                         output logic [31:0] rv, output logic rf);
      logic [31:0] ea;
      logic [31:0] ld;
      int nb;
      int n;
      bit flt;
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      ea = (sz == 2'd1) ? {a[31:1], 1'b0}
         : (sz == 2'd2) ? {a[31:2], 2'b00} : a;
      flt = (sz == 2'd3) || (TRAP && (ea != a));
      ld = 32'd0;
      for (int i = 0; i < nb; i++) begin
         ld[8*i +: 8] = ref_mem[ea[7:0] + 8'(i)];
      end
      if (!u && nb < 4 && ld[8*nb-1]) begin
         ld = ld | ~((32'd1 << (8*nb)) - 32'd1);
      end
      exp_fault = flt;
      exp_addr  = {ea[31:2], 2'b00};
      exp_mask  = (w && !flt) ? 4'(((1 << nb) - 1) << ea[1:0]) : 4'd0;
      exp_wdata = (sz == 2'd0) ? v[7:0] * 32'h01010101
                : (sz == 2'd1) ? v[15:0] * 32'h00010001 : v;
      exp_value = (w || flt) ? 32'd0 : ld;
      access_seen = 0;
      last_mask = 4'd0;

      bus.req_valid_in    = 1'b1;
      bus.req_write_in    = w;
      bus.req_size_in     = sz;
      bus.req_unsigned_in = u;
      bus.req_address_in  = a;
      bus.req_value_in    = v;
      chk("req_ready_idle", {31'd0, bus.req_ready_out}, 32'd1);
      @(posedge clk); #1;
      bus.req_valid_in = 1'b0;
      n = 0;
      while (!bus.rsp_valid_out && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rsp_arrived", {31'd0, bus.rsp_valid_out}, 32'd1);
      rv = bus.rsp_value_out;
      rf = bus.rsp_fault_out;
      for (int i = 0; i < hold; i++) begin
         if (i == 0) begin
            // Foreign store presented while busy must be ignored.
            bus.req_valid_in   = 1'b1;
            bus.req_write_in   = 1'b1;
            bus.req_size_in    = 2'd2;
            bus.req_address_in = 32'h50;
            bus.req_value_in   = 32'hBAD0BAD0;
         end
         @(posedge clk); #1;
         chk("hold_valid", {31'd0, bus.rsp_valid_out}, 32'd1);
         chk("hold_ready", {31'd0, bus.req_ready_out}, 32'd0);
      end
      bus.req_valid_in = 1'b0;
      bus.rsp_ready_in = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready_in = 1'b0;
      chk("back_to_idle", {30'd0, bus.rsp_valid_out, bus.req_ready_out},
          32'd1);
      chk("access_cycles", 32'(access_seen), flt ? 32'd0 : 32'd1);
      if (w && !flt) begin
         for (int i = 0; i < nb; i++) begin
            ref_mem[ea[7:0] + 8'(i)] = v[8*i +: 8];
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rv;
      logic rf;
      for (int i = 0; i < 256; i++) begin
         ram[i]     = 8'(i) ^ 8'h5A;
         ref_mem[i] = 8'(i) ^ 8'h5A;
      end
      bus.req_valid_in    = 1'b0;
      bus.req_write_in    = 1'b0;
      bus.req_size_in     = 2'd0;
      bus.req_unsigned_in = 1'b0;
      bus.req_address_in  = 32'd0;
      bus.req_value_in    = 32'd0;
      bus.rsp_ready_in    = 1'b0;
      #1;
      chk("rst_ready", {31'd0, bus.req_ready_out}, 32'd1);
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid_out}, 32'd0);
      chk("rst_rsp_fault", {31'd0, bus.rsp_fault_out}, 32'd0);
      chk("rst_rsp_value", bus.rsp_value_out, 32'd0);
      chk("rst_mask", {28'd0, bus.ram_write_mask_out}, 32'd0);
      chk("rst_addr", bus.ram_address_out, 32'd0);
      chk("rst_wdata", bus.ram_write_value_out, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      do_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, rv, rf);
      chk("sw_mask_lit", {28'd0, last_mask}, 32'h0000000F);
      chk("sw_value_lit", rv, 32'd0);
      do_req(0, 2'd2, 0, 32'h10, 32'd0, 0, rv, rf);
      chk("lw_lit", rv, 32'hDEADBEEF);
      chk("lw_fault_lit", {31'd0, rf}, 32'd0);

      do_req(1, 2'd0, 0, 32'h13, 32'h00000080, 0, rv, rf);
      chk("sb_mask_lit", {28'd0, last_mask}, 32'h00000008);
      do_req(0, 2'd0, 0, 32'h13, 32'd0, 0, rv, rf);
      chk("lb_lit", rv, 32'hFFFFFF80);
      do_req(0, 2'd0, 1, 32'h13, 32'd0, 0, rv, rf);
      chk("lbu_lit", rv, 32'h00000080);

      do_req(1, 2'd1, 0, 32'h22, 32'h00001234, 0, rv, rf);
      chk("sh_mask_lit", {28'd0, last_mask}, 32'h0000000C);
      do_req(0, 2'd1, 0, 32'h22, 32'd0, 0, rv, rf);
      chk("lh_lit", rv, 32'h00001234);

      do_req(0, 2'd2, 0, 32'h21, 32'd0, 0, rv, rf);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("lw_mis_fault_lit", {31'd0, rf}, 32'd1);
      chk("lw_mis_value_lit", rv, 32'd0);
`else
      chk("lw_mis_fault_lit", {31'd0, rf}, 32'd0);
      chk("lw_mis_value_lit", rv, 32'h12347B7A);
`endif

      do_req(0, 2'd3, 0, 32'h30, 32'd0, 0, rv, rf);
      chk("size3_fault_lit", {31'd0, rf}, 32'd1);
      do_req(1, 2'd3, 0, 32'h30, 32'h11111111, 0, rv, rf);
      do_req(0, 2'd2, 0, 32'h30, 32'd0, 0, rv, rf);

      do_req(0, 2'd0, 1, 32'h11, 32'd0, 4, rv, rf);
      chk("hold_lbu_lit", rv, 32'h000000BE);

      do_req(1, 2'd1, 0, 32'h25, 32'h0000ABCD, 0, rv, rf);
      do_req(0, 2'd1, 0, 32'h24, 32'd0, 0, rv, rf);
      do_req(0, 2'd1, 1, 32'h26, 32'd0, 0, rv, rf);
      do_req(0, 2'd2, 0, 32'h50, 32'd0, 0, rv, rf);

      // Reset in the middle of a store's ACCESS cycle.
      bus.req_valid_in   = 1'b1;
      bus.req_write_in   = 1'b1;
      bus.req_size_in    = 2'd2;
      bus.req_address_in = 32'h40;
      bus.req_value_in   = 32'hCAFEF00D;
      @(posedge clk); #1;
      bus.req_valid_in = 1'b0;
      chk("mid_access_busy", {31'd0, bus.req_ready_out}, 32'd0);
      chk("mid_access_mask", {28'd0, bus.ram_write_mask_out}, 32'hF);
      #2 reset = 1'b1;
      #1;
      chk("rst_async_mask", {28'd0, bus.ram_write_mask_out}, 32'd0);
      chk("rst_async_ready", {31'd0, bus.req_ready_out}, 32'd1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("post_rst_no_rsp", {31'd0, bus.rsp_valid_out}, 32'd0);
         chk("post_rst_idle", {31'd0, bus.req_ready_out}, 32'd1);
      end
      do_req(0, 2'd2, 0, 32'h40, 32'd0, 0, rv, rf);
      chk("no_write_lit", rv, 32'h19181B1A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
